instr_mem_loader: RTL

// - Writer side of instruction memory: accepts a program as a byte stream (valid/ready), packs bytes

---
 rtl/instr_mem_loader_pkg.sv | 17 +
 rtl/instr_mem_loader_if.sv | 35 +++
 rtl/instr_mem_loader_byte_packer.sv | 43 ++++
 rtl/instr_mem_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM states and sizing defaults.
package instr_mem_loader_pkg;

  localparam int PROG_LEN_MAX_DEFAULT = 256;
  localparam int CNT_W_DEFAULT        = 16;
  localparam int WORD_BYTES           = 4;
  localparam int INSTR_W              = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host byte stream, instruction memory write port and core start-up controls of the loader.
interface instr_mem_loader_if
  import instr_mem_loader_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic               start;
  logic [CNT_W-1:0]   word_count;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic [INSTR_W-1:0] instr_addr;
  logic [INSTR_W-1:0] instr_data;
  logic               instr_write;
  logic               instr_read;
  logic               initializing;
  logic               pc_reset;
  logic               pc_write;
  logic               done;
  logic               error;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, instr_addr, instr_data, instr_write, instr_read,
           initializing, pc_reset, pc_write, done, error
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, instr_addr, instr_data, instr_write, instr_read,
           initializing, pc_reset, pc_write, done, error
  );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid flags the 4th byte of each word.
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);

  logic [1:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] word_q, word_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // Shifting left puts the first byte of a word in bits [31:24] once all four are in.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = 2'd0;
      word_d = '0;
    end else if (shift_en) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {word_q[INSTR_W-9:0], byte_in};
    end
  end

  assign word       = word_q;
  assign word_valid = shift_en && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte-streamed program into instruction memory, then releases the PC to the core.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int PROG_LEN_MAX = PROG_LEN_MAX_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  instr_mem_loader_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(PROG_LEN_MAX);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   idx_inc;
  logic               error_q, error_d;
  logic               load_xfer;
  logic               pack_clear;
  logic               word_valid;
  logic [INSTR_W-1:0] packed_word;

  assign load_xfer = (state_q == ST_LOAD) && bus.byte_valid;
  assign idx_inc   = idx_q + CNT_W'(1);

  instr_mem_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .shift_en   (load_xfer),
    .byte_in    (bus.byte_in),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    error_d    = error_q;
    pack_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.word_count == '0) begin
            state_d = ST_RELEASE;
          end else if (bus.word_count > MAX_COUNT) begin
            error_d = 1'b1;
          end else begin
            count_d    = bus.word_count;
            idx_d      = '0;
            pack_clear = 1'b1;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (word_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == count_q) ? ST_RELEASE : ST_LOAD;
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Every output is a decode of registered state, so nothing on the byte input reaches them.
  always_comb begin
    bus.byte_ready   = 1'b0;
    bus.instr_addr   = '0;
    bus.instr_data   = '0;
    bus.instr_write  = 1'b0;
    bus.instr_read   = 1'b0;
    bus.initializing = 1'b1;
    bus.pc_reset     = 1'b1;
    bus.pc_write     = 1'b0;
    bus.done         = 1'b0;
    bus.error        = error_q;
    case (state_q)
      ST_LOAD: bus.byte_ready = 1'b1;
      ST_WRITE: begin
        bus.instr_write = 1'b1;
        bus.instr_addr  = INSTR_W'({idx_q, 2'b00});
        bus.instr_data  = packed_word;
      end
      ST_RUN: begin
        bus.initializing = 1'b0;
        bus.pc_reset     = 1'b0;
        bus.pc_write     = 1'b1;
        bus.instr_read   = 1'b1;
        bus.done         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
